// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory port arbiter between CPU MEM stage and DMA, with locked DMA bursts
// Optional starvation protection: define DMEM_ARB_FAIRNESS_EN.
module dmem_arbiter #(
    parameter int ADDR_LEN  = 8,
    parameter int WORD_LEN  = 8,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_LEN-1:0] cpu_addr,
    input  logic [WORD_LEN-1:0] cpu_wdata,
    output logic [WORD_LEN-1:0] cpu_rdata,
    output logic                cpu_stall,
    input  logic                dma_req,
    input  logic                dma_we,
    input  logic                dma_lock,
    input  logic [ADDR_LEN-1:0] dma_addr,
    input  logic [WORD_LEN-1:0] dma_wdata,
    output logic                dma_gnt,
    output logic [WORD_LEN-1:0] dma_rdata,
    output logic                dma_rvalid,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [WORD_LEN-1:0] mem_wdata,
    output logic                mem_read,
    output logic                mem_write,
    input  logic [WORD_LEN-1:0] mem_rdata
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT out of range 1..15");
    end
    if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst_max
        $error("dmem_arbiter: BURST_MAX out of range 1..15");
    end

    typedef enum logic [0:0] {
        ARB_CPU   = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    arb_state_t state;
    logic [3:0] beat_cnt;
    logic       cpu_grant;
    logic       dma_grant;
    logic       force_dma;
    logic       burst_more;

`ifdef DMEM_ARB_FAIRNESS_EN
    logic [3:0] wait_cnt;

    assign force_dma = dma_req && (wait_cnt == 4'(MAX_WAIT));

    // Counts consecutive denied DMA cycles; any grant, idle DMA or burst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (state == ARB_CPU && dma_req && !dma_grant) begin
            if (wait_cnt != 4'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else begin
            wait_cnt <= 4'd0;
        end
    end
`else
    assign force_dma = 1'b0;
`endif

    assign burst_more = dma_req && dma_lock && (beat_cnt < 4'(BURST_MAX));

    always_comb begin
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        case (state)
            ARB_CPU: begin
                if (force_dma) begin
                    dma_grant = 1'b1;
                end else if (cpu_req) begin
                    cpu_grant = 1'b1;
                end else if (dma_req) begin
                    dma_grant = 1'b1;
                end
            end
            ARB_BURST: begin
                // When the burst cannot continue the CPU gets this slot unconditionally.
                if (burst_more) begin
                    dma_grant = 1'b1;
                end else begin
                    cpu_grant = cpu_req;
                end
            end
            default: begin
                cpu_grant = 1'b0;
                dma_grant = 1'b0;
            end
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (dma_grant) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (cpu_grant) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    assign mem_read  = (dma_grant & ~dma_we) | (cpu_grant & ~cpu_we);
    assign mem_write = (dma_grant & dma_we) | (cpu_grant & cpu_we);
    assign cpu_rdata = mem_rdata;
    assign cpu_stall = cpu_req & ~cpu_grant;
    assign dma_gnt   = dma_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_CPU;
            beat_cnt   <= 4'd0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
        end else begin
            dma_rvalid <= dma_grant & ~dma_we;
            if (dma_grant && !dma_we) begin
                dma_rdata <= mem_rdata;
            end
            case (state)
                ARB_CPU: begin
                    if (dma_grant && dma_lock) begin
                        state    <= ARB_BURST;
                        beat_cnt <= 4'd1;
                    end
                end
                ARB_BURST: begin
                    if (dma_grant) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end else begin
                        state    <= ARB_CPU;
                        beat_cnt <= 4'd0;
                    end
                end
                default: begin
                    state    <= ARB_CPU;
                    beat_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule
